capture_controller: RTL

Sequencer for one sampler capture cycle. It arms the sampler, then holds the write gate open until the 1024-entry buffer has filled. It then drains the stored samples one at a time into a byte-serial transmitter (UART-style start/busy handshake) by pulsing the sampler's advance input. It sits between the top-level command logic and the sampler/transmitter pair, and reports progress, completion and timeout.

---
 rtl/capture_controller_pkg.sv | 17 +
 rtl/capture_controller_wait_timer.sv | 18 +
 rtl/capture_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/capture_controller_pkg.sv
// capture_controller_pkg: state encoding, sizing defaults and the counter width helper
package capture_controller_pkg;
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_ARM    = 4'd1;
  localparam logic [3:0] ST_FILL   = 4'd2;
  localparam logic [3:0] ST_SEND   = 4'd3;
  localparam logic [3:0] ST_TXWAIT = 4'd4;
  localparam logic [3:0] ST_DROP   = 4'd5;
  localparam logic [3:0] ST_RISE   = 4'd6;
  localparam logic [3:0] ST_DONE   = 4'd7;
  localparam logic [3:0] ST_ERROR  = 4'd8;
  localparam int MEM_SIZE = 1024;
  localparam int DEFAULT_SAMPLE_COUNT = MEM_SIZE;
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/capture_controller_wait_timer.sv
// wait_timer: clearable up-counter that stops at a programmable terminal value
module wait_timer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] value,
  output logic             hit
);
  assign hit = value == limit;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) value <= '0;
    else if (clear) value <= '0;
    else if (enable && !hit) value <= value + 1'b1;
endmodule

// File: rtl/capture_controller.sv
// capture_controller: arms the sampler, fills its buffer, then drains it byte by byte into the transmitter
module capture_controller
  import capture_controller_pkg::*;
#(
  parameter int DATA_SIZE      = 8,
  parameter int SAMPLE_COUNT   = DEFAULT_SAMPLE_COUNT,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                                 i_clock,
  input  logic                                 i_reset,
  input  logic                                 i_start,
  input  logic                                 i_abort,
  output logic                                 o_adc_init,
  output logic                                 o_gate,
  output logic                                 o_next,
  input  logic [DATA_SIZE-1:0]                 i_smp_data,
  input  logic                                 i_smp_valid,
  output logic [DATA_SIZE-1:0]                 o_tx_data,
  output logic                                 o_tx_start,
  input  logic                                 i_tx_busy,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_error,
  output logic [count_width(SAMPLE_COUNT)-1:0] o_count
);
  localparam int CW = count_width(SAMPLE_COUNT);
  localparam int TW = count_width((SETTLE_CYCLES > TIMEOUT_CYCLES ? SETTLE_CYCLES : TIMEOUT_CYCLES) - 1);
  logic [3:0]    state, state_next;
  logic [CW-1:0] count_next;
  logic [TW-1:0] timer_value, timer_limit;
  logic timer_hit, waiting, active_next;
  logic latch, launch, advance, count_clear, count_inc;
  assign waiting = state inside {ST_FILL, ST_SEND, ST_TXWAIT, ST_DROP, ST_RISE};
  assign active_next = state_next inside {ST_ARM, ST_FILL, ST_SEND, ST_TXWAIT, ST_DROP, ST_RISE};
  assign timer_limit = (state == ST_ARM) ? TW'(SETTLE_CYCLES - 1) : TW'(TIMEOUT_CYCLES - 1);
  // one timer serves both the settle delay and the waiting-state timeout; any state change restarts it
  wait_timer #(.WIDTH(TW)) u_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .clear   (state_next != state),
    .enable  (waiting || state == ST_ARM),
    .limit   (timer_limit),
    .value   (timer_value),
    .hit     (timer_hit)
  );
  always_comb begin
    state_next  = state;
    latch       = 1'b0;
    launch      = 1'b0;
    advance     = 1'b0;
    count_clear = 1'b0;
    count_inc   = 1'b0;
    if (i_abort && state != ST_IDLE) state_next = ST_IDLE;
    else if (waiting && timer_hit) state_next = ST_ERROR;
    else
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR:
          if (i_start) begin
            state_next  = ST_ARM;
            count_clear = 1'b1;
          end
        ST_ARM: if (timer_hit) state_next = ST_FILL;
        ST_FILL, ST_RISE:
          if (i_smp_valid) begin
            state_next = ST_SEND;
            latch      = 1'b1;
          end
        ST_SEND:
          if (!i_tx_busy) begin
            state_next = ST_TXWAIT;
            launch     = 1'b1;
          end
        // first TXWAIT cycle (timer still 0) is skipped so the busy rise can land
        ST_TXWAIT:
          if (timer_value != '0 && !i_tx_busy) begin
            count_inc = 1'b1;
            if (o_count == CW'(SAMPLE_COUNT - 1)) state_next = ST_DONE;
            else begin
              state_next = ST_DROP;
              advance    = 1'b1;
            end
          end
        ST_DROP: if (!i_smp_valid) state_next = ST_RISE;
        default: state_next = ST_IDLE;
      endcase
  end
  assign count_next = count_clear ? '0 :
                      (count_inc && o_count != CW'(SAMPLE_COUNT)) ? o_count + 1'b1 : o_count;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state   <= ST_IDLE;
      o_count <= '0;
    end else begin
      state   <= state_next;
      o_count <= count_next;
    end
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      o_adc_init <= 1'b0;
      o_gate     <= 1'b0;
      o_next     <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      o_adc_init <= active_next;
      o_busy     <= active_next;
      o_gate     <= state_next == ST_FILL;
      o_next     <= advance;
      o_tx_start <= launch;
      o_done     <= state_next == ST_DONE;
      o_error    <= state_next == ST_ERROR;
      if (latch) o_tx_data <= i_smp_data;
    end
endmodule
